// File: rtl/vm_pkg.sv
// Shared types for the vending machine: state encoding, coin codes, coin-value decode.
package vm_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StCredit = 2'b01,
      StVend   = 2'b10,
      StChange = 2'b11
   } vm_state_e;

   localparam logic [1:0] CoinNone = 2'b00;
   localparam logic [1:0] CoinC1   = 2'b01;
   localparam logic [1:0] CoinC2   = 2'b10;
   localparam logic [1:0] CoinC3   = 2'b11;

   // Map a coin code to its value in credit units.
   function automatic int unsigned coin_value(input logic [1:0]  code,
                                              input int unsigned v1,
                                              input int unsigned v2,
                                              input int unsigned v3);
      int unsigned val;
      val = 0;
      unique case (code)
         CoinC1:  val = v1;
         CoinC2:  val = v2;
         CoinC3:  val = v3;
         default: val = 0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters with decrement strobe, restock and sold-out flags.
module vm_stock_bank
   import vm_pkg::*;
#(
   parameter  int unsigned NUM_ITEMS  = 4,
   parameter  int unsigned STOCK_INIT = 2,
   localparam int unsigned SEL_W      = $clog2(NUM_ITEMS),
   localparam int unsigned STOCK_W    = $clog2(STOCK_INIT + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 dec_i,
   input  logic [SEL_W-1:0]     dec_idx_i,
   input  logic                 restock_i,
   output logic [NUM_ITEMS-1:0] sold_out_o
);

   logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

   // Next stock: restock wins, otherwise decrement the selected item without underflow.
   always_comb begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
         stock_d[i] = stock_q[i];
         if (restock_i) begin
            stock_d[i] = STOCK_W'(STOCK_INIT);
         end else if (dec_i && (dec_idx_i == SEL_W'(i)) && (stock_q[i] != '0)) begin
            stock_d[i] = stock_q[i] - STOCK_W'(1);
         end
      end
   end

   // Stock registers, refilled on reset.
   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
         if (rst_i) begin
            stock_q[i] <= STOCK_W'(STOCK_INIT);
         end else begin
            stock_q[i] <= stock_d[i];
         end
      end
   end

   // Sold-out flags straight from the counters.
   always_comb begin
      sold_out_o = '0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
         sold_out_o[i] = (stock_q[i] == '0);
      end
   end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised multi-item vending FSM with credit ceiling and one-unit change pulses.
// Optional restock port enabled by defining VM_RESTOCK_EN.
module vending_machine_param
   import vm_pkg::*;
#(
   parameter  int unsigned PRICE      = 3,
   parameter  int unsigned MAX_CREDIT = 7,
   parameter  int unsigned COIN1_VAL  = 1,
   parameter  int unsigned COIN2_VAL  = 2,
   parameter  int unsigned COIN3_VAL  = 4,
   parameter  int unsigned NUM_ITEMS  = 4,
   parameter  int unsigned STOCK_INIT = 2,
   localparam int unsigned CREDIT_W   = $clog2(MAX_CREDIT + 1),
   localparam int unsigned SEL_W      = $clog2(NUM_ITEMS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           in,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 vend_req,
   input  logic                 cancel,
`ifdef VM_RESTOCK_EN
   input  logic                 restock,
`endif
   output logic                 out,
   output logic [SEL_W-1:0]     out_item,
   output logic                 change,
   output logic                 coin_reject,
   output logic                 vend_err,
   output logic [CREDIT_W-1:0]  credit,
   output logic [NUM_ITEMS-1:0] sold_out,
   output logic                 busy,
   output logic [1:0]           c_state,
   output logic [1:0]           n_state
);

   vm_state_e           state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [SEL_W-1:0]    out_item_q, out_item_d;
   logic                out_q, out_d;
   logic                change_q, change_d;
   logic                coin_reject_q, coin_reject_d;
   logic                vend_err_q, vend_err_d;
   logic                busy_q, busy_d;
   logic                coin_present;
   int unsigned         coin_val;
   int unsigned         coin_sum;
   logic                restock_ok;

`ifdef VM_RESTOCK_EN
   assign restock_ok = restock && (state_q == StIdle);
`else
   assign restock_ok = 1'b0;
`endif

   // out_item_q doubles as the latched selection for the stock decrement during VEND.
   vm_stock_bank #(
      .NUM_ITEMS  (NUM_ITEMS),
      .STOCK_INIT (STOCK_INIT)
   ) u_stock (
      .clk_i      (clk),
      .rst_i      (rst),
      .dec_i      (state_q == StVend),
      .dec_idx_i  (out_item_q),
      .restock_i  (restock_ok),
      .sold_out_o (sold_out)
   );

   // Next-state, credit and registered-output decode.
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      coin_reject_d = 1'b0;
      vend_err_d    = 1'b0;
      coin_present  = (in != CoinNone);
      coin_val      = coin_value(in, COIN1_VAL, COIN2_VAL, COIN3_VAL);
      coin_sum      = 32'(credit_q) + coin_val;
      out_item_d    = '0;
      unique case (state_q)
         StIdle: begin
            if (coin_present) begin
               if (coin_sum <= MAX_CREDIT) begin
                  credit_d = CREDIT_W'(coin_sum);
                  state_d  = StCredit;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end
         StCredit: begin
            if (cancel) begin
               coin_reject_d = coin_present;
               state_d       = StChange;
            end else if (vend_req) begin
               coin_reject_d = coin_present;
               if ((32'(credit_q) >= PRICE) && !sold_out[sel]) begin
                  out_item_d = sel;
                  state_d    = StVend;
               end else begin
                  vend_err_d = 1'b1;
               end
            end else if (coin_present) begin
               if (coin_sum <= MAX_CREDIT) begin
                  credit_d = CREDIT_W'(coin_sum);
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end
         StVend: begin
            coin_reject_d = coin_present;
            credit_d      = credit_q - CREDIT_W'(PRICE);
            state_d       = (32'(credit_q) > PRICE) ? StChange : StIdle;
         end
         StChange: begin
            coin_reject_d = coin_present;
            // Leave on the pulse that drains the last unit.
            if (credit_q <= CREDIT_W'(1)) begin
               credit_d = '0;
               state_d  = StIdle;
            end else begin
               credit_d = credit_q - CREDIT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      out_d    = (state_d == StVend);
      change_d = (state_d == StChange);
      busy_d   = (state_d == StVend) || (state_d == StChange);
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         credit_q      <= '0;
         out_item_q    <= '0;
         out_q         <= 1'b0;
         change_q      <= 1'b0;
         coin_reject_q <= 1'b0;
         vend_err_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         out_item_q    <= out_item_d;
         out_q         <= out_d;
         change_q      <= change_d;
         coin_reject_q <= coin_reject_d;
         vend_err_q    <= vend_err_d;
         busy_q        <= busy_d;
      end
   end

   assign out         = out_q;
   assign out_item    = out_item_q;
   assign change      = change_q;
   assign coin_reject = coin_reject_q;
   assign vend_err    = vend_err_q;
   assign credit      = credit_q;
   assign busy        = busy_q;
   assign c_state     = state_q;
   assign n_state     = state_d;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed scoreboard bench for vending_machine_param at default parameters.
module tb_vending_machine_param;

   localparam logic [1:0] SI = 2'd0;
   localparam logic [1:0] SC = 2'd1;
   localparam logic [1:0] SV = 2'd2;
   localparam logic [1:0] SH = 2'd3;

   logic       clk;
   logic       rst;
   logic [1:0] in;
   logic [1:0] sel;
   logic       vend_req;
   logic       cancel;
`ifdef VM_RESTOCK_EN
   logic       restock;
`endif
   logic       out;
   logic [1:0] out_item;
   logic       change;
   logic       coin_reject;
   logic       vend_err;
   logic [2:0] credit;
   logic [3:0] sold_out;
   logic       busy;
   logic [1:0] c_state;
   logic [1:0] n_state;

   int vectors;
   int miscompares;

   logic [15:0] exp_q[$];
   string       tag_q[$];

   vending_machine_param dut (
      .clk         (clk),
      .rst         (rst),
      .in          (in),
      .sel         (sel),
      .vend_req    (vend_req),
      .cancel      (cancel),
`ifdef VM_RESTOCK_EN
      .restock     (restock),
`endif
      .out         (out),
      .out_item    (out_item),
      .change      (change),
      .coin_reject (coin_reject),
      .vend_err    (vend_err),
      .credit      (credit),
      .sold_out    (sold_out),
      .busy        (busy),
      .c_state     (c_state),
      .n_state     (n_state)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mk(input logic o, input logic [1:0] it, input logic ch,
                                      input logic rj, input logic er, input logic [2:0] cr,
                                      input logic [3:0] so, input logic bz, input logic [1:0] st);
      return {o, it, ch, rj, er, cr, so, bz, st};
   endfunction

   task automatic check_front();
      logic [15:0] e;
      logic [15:0] obs;
      string       t;
      obs = {out, out_item, change, coin_reject, vend_err, credit, sold_out, busy, c_state};
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
         end
      end
   endtask

   // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
   task automatic step(input string tag, input logic [1:0] c, input logic vr, input logic cn,
                       input logic [1:0] s, input logic r, input logic [15:0] e);
      in       = c;
      vend_req = vr;
      cancel   = cn;
      sel      = s;
      rst      = r;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      in       = 2'b00;
      vend_req = 1'b0;
      cancel   = 1'b0;
      rst      = 1'b0;
      check_front();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clk         = 1'b0;
      rst         = 1'b1;
      in          = 2'b00;
      sel         = 2'd0;
      vend_req    = 1'b0;
      cancel      = 1'b0;
`ifdef VM_RESTOCK_EN
      restock     = 1'b0;
`endif
      vectors     = 0;
      miscompares = 0;
      #2;

      // Scenario 1: 01 + 10, vend item 2, then confirm item 2 has one left.
      step("reset", 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
      in = 2'b01;
      #1;
      vectors++;
      assert (n_state === SC) else begin
         miscompares++;
         $error("FAIL n_state_comb: observed %0d expected %0d", n_state, SC);
      end
      step("s1_coin1", 2'b01, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd1, 4'h0, 0, SC));
      step("s1_coin2", 2'b10, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd3, 4'h0, 0, SC));
      step("s1_vend", 2'b00, 1'b1, 1'b0, 2'd2, 1'b0, mk(1, 2'd2, 0, 0, 0, 3'd3, 4'h0, 1, SV));
      step("s1_idle", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
      step("s1_cancel_idle", 2'b00, 1'b0, 1'b1, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
      step("s1_coin3", 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd4, 4'h0, 0, SC));
      step("s1_vend2", 2'b00, 1'b1, 1'b0, 2'd2, 1'b0, mk(1, 2'd2, 0, 0, 0, 3'd4, 4'h0, 1, SV));
      step("s1_chg", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 1, 0, 0, 3'd1, 4'h4, 1, SH));
      step("s1_done", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h4, 0, SI));
      step("s1_coin3b", 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd4, 4'h4, 0, SC));
      step("s1_soldout", 2'b00, 1'b1, 1'b0, 2'd2, 1'b0, mk(0, 2'd0, 0, 0, 1, 3'd4, 4'h4, 0, SC));

      // Scenario 2: coin 11, vend item 0, one change pulse.
      step("s2_reset", 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
      step("s2_coin3", 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd4, 4'h0, 0, SC));
      step("s2_vend", 2'b00, 1'b1, 1'b0, 2'd0, 1'b0, mk(1, 2'd0, 0, 0, 0, 3'd4, 4'h0, 1, SV));
      step("s2_chg", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 1, 0, 0, 3'd1, 4'h0, 1, SH));
      step("s2_idle", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
      step("s2_stay", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));

      // Scenario 3: coin 10 then cancel, two change pulses; coin in CHANGE refused.
      step("s3_reset", 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
      step("s3_coin2", 2'b10, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd2, 4'h0, 0, SC));
      step("s3_cancel", 2'b00, 1'b0, 1'b1, 2'd0, 1'b0, mk(0, 2'd0, 1, 0, 0, 3'd2, 4'h0, 1, SH));
      step("s3_chg2", 2'b01, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 1, 1, 0, 3'd1, 4'h0, 1, SH));
      step("s3_idle", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));

      // Scenario 4: sell out item 1 with exact credit, then a refused request.
      step("s4_reset", 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
      for (int k = 0; k < 2; k++) begin
         step("s4_c1", 2'b01, 1'b0, 1'b0, 2'd0, 1'b0,
              mk(0, 2'd0, 0, 0, 0, 3'd1, (k == 0) ? 4'h0 : 4'h0, 0, SC));
         step("s4_c2", 2'b10, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd3, 4'h0, 0, SC));
         step("s4_vend", 2'b00, 1'b1, 1'b0, 2'd1, 1'b0, mk(1, 2'd1, 0, 0, 0, 3'd3, 4'h0, 1, SV));
         step("s4_idle", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0,
              mk(0, 2'd0, 0, 0, 0, 3'd0, (k == 0) ? 4'h0 : 4'h2, 0, SI));
      end
      step("s4_coin3", 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd4, 4'h2, 0, SC));
      step("s4_err", 2'b00, 1'b1, 1'b0, 2'd1, 1'b0, mk(0, 2'd0, 0, 0, 1, 3'd4, 4'h2, 0, SC));
      step("s4_err_clr", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd4, 4'h2, 0, SC));

      // Scenario 5: ceiling overflow reject, and coin with vend_req rejected.
      step("s5_reset", 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
      step("s5_coin3", 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd4, 4'h0, 0, SC));
      step("s5_over", 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 1, 0, 3'd4, 4'h0, 0, SC));
      step("s5_coin_vend", 2'b01, 1'b1, 1'b0, 2'd0, 1'b0, mk(1, 2'd0, 0, 1, 0, 3'd4, 4'h0, 1, SV));
      step("s5_chg", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 1, 0, 0, 3'd1, 4'h0, 1, SH));
      step("s5_idle", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));

      // Scenario 6: reset during CHANGE, then item 3 still sells twice.
      step("s6_reset", 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
      step("s6_coin3", 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd4, 4'h0, 0, SC));
      step("s6_vend", 2'b00, 1'b1, 1'b0, 2'd3, 1'b0, mk(1, 2'd3, 0, 0, 0, 3'd4, 4'h0, 1, SV));
      step("s6_chg", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 1, 0, 0, 3'd1, 4'h0, 1, SH));
      step("s6_rst_chg", 2'b00, 1'b0, 1'b0, 2'd0, 1'b1, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
      for (int k = 0; k < 2; k++) begin
         step("s6_c3", 2'b11, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd4, 4'h0, 0, SC));
         step("s6_c_rej", 2'b11, 1'b0, 1'b1, 2'd0, 1'b0, mk(0, 2'd0, 1, 1, 0, 3'd4, 4'h0, 1, SH));
         step("s6_drain", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 1, 0, 0, 3'd3, 4'h0, 1, SH));
         step("s6_drain", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 1, 0, 0, 3'd2, 4'h0, 1, SH));
         step("s6_drain", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 1, 0, 0, 3'd1, 4'h0, 1, SH));
         step("s6_drained", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd0, 4'h0, 0, SI));
         step("s6_c1", 2'b01, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd1, 4'h0, 0, SC));
         step("s6_c2", 2'b10, 1'b0, 1'b0, 2'd0, 1'b0, mk(0, 2'd0, 0, 0, 0, 3'd3, 4'h0, 0, SC));
         step("s6_buy3", 2'b00, 1'b1, 1'b0, 2'd3, 1'b0, mk(1, 2'd3, 0, 0, 0, 3'd3, 4'h0, 1, SV));
         step("s6_after", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0,
              mk(0, 2'd0, 0, 0, 0, 3'd0, (k == 0) ? 4'h0 : 4'h8, 0, SI));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vending_machine_param.md
# vending_machine_param

Parametrised successor to the single-product vending FSM. Accepts three coin denominations, holds credit up to a ceiling, and vends one of `NUM_ITEMS` products with per-item stock tracking. Returns surplus or cancelled credit as a train of one-unit change pulses. Sits between the coin-acceptor/keypad front end and the dispenser actuators.

## Interface
Parameters:
- `PRICE`, 3: price of every item, in credit units; must satisfy 1 ≤ `PRICE` ≤ `MAX_CREDIT`.
- `MAX_CREDIT`, 7: credit ceiling in units.
- `COIN1_VAL`, 1: value of coin code 2'b01, in units.
- `COIN2_VAL`, 2: value of coin code 2'b10, in units.
- `COIN3_VAL`, 4: value of coin code 2'b11, in units.
- `NUM_ITEMS`, 4: number of products, ≥ 2.
- `STOCK_INIT`, 2: stock per item after reset or restock, ≥ 1.

Derived widths: `CREDIT_W = $clog2(MAX_CREDIT+1)`, `SEL_W = $clog2(NUM_ITEMS)`, `STOCK_W = $clog2(STOCK_INIT+1)`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  in  2  coin code: 00 none, 01/10/11 are COIN1/2/3. Valid for one cycle per coin.
- `sel`  in  SEL_W  item select, sampled together with `vend_req`.
- `vend_req`  in  1  purchase request, single-cycle pulse.
- `cancel`  in  1  refund request, single-cycle pulse.
- `restock`  in  1  present only with `VM_RESTOCK_EN`.
- `out`  out  1  vend pulse, 1 cycle.
- `out_item`  out  SEL_W  item being vended; valid while `out` is 1.
- `change`  out  1  one-unit change pulse.
- `coin_reject`  out  1  coin refused, 1-cycle pulse.
- `vend_err`  out  1  request refused, 1-cycle pulse.
- `credit`  out  CREDIT_W  current credit.
- `sold_out`  out  NUM_ITEMS  bit i is 1 when stock[i] == 0.
- `busy`  out  1  1 in VEND or CHANGE.
- `c_state`  out  2  current state, for debug.
- `n_state`  out  2  next state, combinational, for debug.

## Operation
States: IDLE=00, CREDIT=01, VEND=10, CHANGE=11.

- **IDLE**: `credit` is 0. A nonzero coin adds its value and moves to CREDIT.
- **CREDIT**: input priority is `cancel` > `vend_req` > coin.
  - `cancel`: go to CHANGE.
  - `vend_req` with `credit` ≥ `PRICE` and stock[`sel`] > 0: latch `sel`, go to VEND.
  - `vend_req` otherwise: `vend_err` = 1 next cycle. Stay in CREDIT; credit and stock are unchanged.
  - Coin: added to `credit` if the sum is ≤ `MAX_CREDIT`. Otherwise the coin is refused, `credit` is unchanged and `coin_reject` = 1.
  - A coin arriving in the same cycle as `cancel` or `vend_req` is rejected.
- **VEND** (exactly 1 cycle): `out` = 1 and `out_item` = latched select. On exit, stock[item] decrements and `credit` drops by `PRICE`. Next state is CHANGE if the remainder is > 0, else IDLE.
- **CHANGE**: `change` = 1 every cycle and `credit` decrements by 1 each cycle. Exit to IDLE on the cycle credit reaches 0. Total pulses equal the credit on entry.
- In VEND and CHANGE, every coin is rejected and `vend_req` / `cancel` are ignored without raising an error.
- `cancel` in IDLE is ignored.
- Stock never underflows. `sold_out` is combinational from the stock registers.

## Timing
- All outputs except `n_state` and `sold_out` are registered.
- Reset values: state IDLE, `credit` 0, every stock = `STOCK_INIT`, and `out`, `out_item`, `change`, `coin_reject`, `vend_err`, `busy` all 0.
- `credit` reflects a coin the cycle after sampling.
- `vend_req` sampled at edge k gives `out` high in cycle k+1, and the first `change` pulse in cycle k+2.
- Change pulses are back-to-back with no gaps.
- Reset mid-VEND or mid-CHANGE: remaining credit is discarded and pulses stop on the next cycle.

## Configuration
`VM_RESTOCK_EN` controls the `restock` port.

With the macro defined:
- The `restock` port exists.
- A `restock` pulse, honoured only in IDLE, sets every stock to `STOCK_INIT` on the next edge.
- `restock` in any other state is ignored.

Without the macro:
- The `restock` port is absent.
- Stock is restored only by `rst`.

## Structure
Package `vm_pkg` holds:
- the state encoding enum, 2 bits;
- coin code localparams: NONE, C1, C2, C3;
- a coin-value decode function taking the code and the three values.

Sub-module `vm_stock_bank` holds:
- the `NUM_ITEMS` stock counters;
- the decrement strobe and index;
- the restock logic;
- `sold_out` generation.

## Test plan
All scenarios use the default parameters.
1. Reset, coins 01 then 10, `vend_req` with `sel`=2 → `out`=1 and `out_item`=2 one cycle after the request; no `change`; `credit`=0; stock[2]=1; back in IDLE.
2. Coin 11, `vend_req` with `sel`=0 → `out` pulse, then exactly one `change` pulse, then IDLE with `credit` 0.
3. Coin 10, then `cancel` → two consecutive `change` pulses, `out` never asserted, `credit` counts 2, 1, 0.
4. Buy item 1 twice with exact credit, then insert 11 and request item 1 → `sold_out[1]`=1, `vend_err` pulse, `credit` stays 4.
5. Coin 11 then coin 11 → second coin gives `coin_reject`=1, `credit`=4. Coin 01 in the same cycle as `vend_req` is also rejected.
6. Coin 11, vend item 3, assert `rst` during the CHANGE state → `change`=0 from the next cycle, `credit`=0, all stock=2 (item 3 restored).
